// File: rtl/vga_timing_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pattern_gen_if
//  Purpose  : Bundles the FIFO-side and display-side signals of the VGA
//             timing / pattern generator.
//  Ports    : Mode, rdata_fifo_rd_data/empty/rd_en, Underflow_clr,
//             Red/Green/Blue_Sign, H/V_Sync_sign, De, H/V_addr,
//             Frame_start, Underflow.
//  Modports : master - the environment (FIFO, control, HDMI sink)
//             slave  - the generator itself
//  Revision : 1.0  initial release
// ============================================================================
interface vga_timing_pattern_gen_if #(
    parameter int H_width = 12,
    parameter int V_width = 11
);
    logic [1:0]          Mode;
    logic [15:0]         rdata_fifo_rd_data;
    logic                rdata_fifo_empty;
    logic                rdata_fifo_rd_en;
    logic                Underflow_clr;
    logic [7:0]          Red_Sign;
    logic [7:0]          Green_Sign;
    logic [7:0]          Blue_Sign;
    logic                H_Sync_sign;
    logic                V_Sync_sign;
    logic                De;
    logic [H_width-1:0]  H_addr;
    logic [V_width-1:0]  V_addr;
    logic                Frame_start;
    logic                Underflow;

    modport master (
        output Mode, rdata_fifo_rd_data, rdata_fifo_empty, Underflow_clr,
        input  rdata_fifo_rd_en, Red_Sign, Green_Sign, Blue_Sign,
               H_Sync_sign, V_Sync_sign, De, H_addr, V_addr,
               Frame_start, Underflow
    );

    modport slave (
        input  Mode, rdata_fifo_rd_data, rdata_fifo_empty, Underflow_clr,
        output rdata_fifo_rd_en, Red_Sign, Green_Sign, Blue_Sign,
               H_Sync_sign, V_Sync_sign, De, H_addr, V_addr,
               Frame_start, Underflow
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pattern_gen
//  Purpose  : Parametrised video timing generator. Produces HS/VS/DE with
//             selectable polarity, pixel addresses, and colour taken from the
//             DDR3 read FIFO (GRAY8 / RGB565) or from internal colour-bar and
//             grid patterns. Flags FIFO underflow and marks frame start.
//  Ports    : Sys_clk  - pixel clock
//             Rst_n    - asynchronous active-low reset
//             vif      - slave side of vga_timing_pattern_gen_if
//  Latency  : counters -> pins = RD_LAT + 1 clocks for every registered output;
//             rdata_fifo_rd_en is combinational from the counters.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_pattern_gen #(
    parameter int H_Sync       = 44,
    parameter int H_backporch  = 148,
    parameter int H_data       = 1920,
    parameter int H_Frontporch = 88,
    parameter int V_Sync       = 5,
    parameter int V_backporch  = 36,
    parameter int V_data       = 1080,
    parameter int V_Frontporch = 4,
    parameter bit HS_POL       = 1'b1,
    parameter bit VS_POL       = 1'b1,
    parameter int RD_LAT       = 1,
    parameter int H_width      = $clog2(H_Sync + H_backporch + H_data + H_Frontporch),
    parameter int V_width      = $clog2(V_Sync + V_backporch + V_data + V_Frontporch)
) (
    input  logic                     Sys_clk,
    input  logic                     Rst_n,
    vga_timing_pattern_gen_if.slave  vif
);

    localparam int H_TOTAL = H_Sync + H_backporch + H_data + H_Frontporch;
    localparam int V_TOTAL = V_Sync + V_backporch + V_data + V_Frontporch;
    localparam int BAR_W   = H_data / 8;

    localparam logic [H_width-1:0] H_LAST      = H_width'(H_TOTAL - 1);
    localparam logic [H_width-1:0] H_SYNC_END  = H_width'(H_Sync);
    localparam logic [H_width-1:0] H_ACT_FIRST = H_width'(H_Sync + H_backporch);
    localparam logic [H_width-1:0] H_ACT_LAST  = H_width'(H_Sync + H_backporch + H_data - 1);
    localparam logic [V_width-1:0] V_LAST      = V_width'(V_TOTAL - 1);
    localparam logic [V_width-1:0] V_SYNC_END  = V_width'(V_Sync);
    localparam logic [V_width-1:0] V_ACT_FIRST = V_width'(V_Sync + V_backporch);
    localparam logic [V_width-1:0] V_ACT_LAST  = V_width'(V_Sync + V_backporch + V_data - 1);

    // Grid lines fall on multiples of 32; narrow address buses compare all bits.
    localparam int GH = (H_width < 5) ? H_width : 5;
    localparam int GV = (V_width < 5) ? V_width : 5;

    // Everything a pixel needs to carry while waiting for its FIFO data.
    typedef struct packed {
        logic               hs;
        logic               vs;
        logic               act;
        logic               empty;
        logic [1:0]         mode;
        logic [H_width-1:0] h;
        logic [V_width-1:0] v;
    } pix_t;

    localparam pix_t PIX_IDLE = '0;

    // ---------------- stage 0: counters and raw timing ----------------
    logic [H_width-1:0] h_cnt;
    logic [V_width-1:0] v_cnt;
    logic [1:0]         mode_r;

    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Mode is only sampled at the very first clock of a frame, which is
    // always blanking, so a frame is never rendered in two modes.
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n)
            mode_r <= 2'd0;
        else if (h_cnt == '0 && v_cnt == '0)
            mode_r <= vif.Mode;
    end

    logic act;
    logic rd_en;
    pix_t s0;

    assign act   = (h_cnt >= H_ACT_FIRST) && (h_cnt <= H_ACT_LAST) &&
                   (v_cnt >= V_ACT_FIRST) && (v_cnt <= V_ACT_LAST);
    assign rd_en = act && !mode_r[1];

    assign s0.hs    = (h_cnt < H_SYNC_END);
    assign s0.vs    = (v_cnt < V_SYNC_END);
    assign s0.act   = act;
    assign s0.empty = rd_en && vif.rdata_fifo_empty;
    assign s0.mode  = mode_r;
    assign s0.h     = act ? h_cnt - H_ACT_FIRST : '0;
    assign s0.v     = act ? v_cnt - V_ACT_FIRST : '0;

    assign vif.rdata_fifo_rd_en = rd_en;

    // ---------------- delay line: RD_LAT stages ----------------
    pix_t tap;

    generate
        if (RD_LAT == 0) begin : g_no_dly
            assign tap = s0;
        end else begin : g_dly
            pix_t dly [RD_LAT];
            always_ff @(posedge Sys_clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    for (int i = 0; i < RD_LAT; i++)
                        dly[i] <= PIX_IDLE;
                end else begin
                    dly[0] <= s0;
                    for (int i = 1; i < RD_LAT; i++)
                        dly[i] <= dly[i-1];
                end
            end
            assign tap = dly[RD_LAT-1];
        end
    endgenerate

    // ---------------- colour selection at the tap ----------------
    logic [15:0] d;
    logic [2:0]  bar;
    logic        grid_on;
    logic [23:0] rgb_next;

    assign d       = vif.rdata_fifo_rd_data;
    assign grid_on = (tap.h[GH-1:0] == '0) || (tap.v[GV-1:0] == '0);

    always_comb begin
        bar = 3'd0;
        for (int b = 1; b < 8; b++)
            if (tap.h >= H_width'(b * BAR_W))
                bar = 3'(b);
    end

    always_comb begin
        rgb_next = 24'h000000;
        // An underflowed pixel keeps its DE slot but is painted black.
        if (tap.act && !tap.empty) begin
            case (tap.mode)
                2'd0:    rgb_next = {d[7:0], d[7:0], d[7:0]};
                2'd1:    rgb_next = {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
                2'd2: begin
                    case (bar)
                        3'd0:    rgb_next = 24'hFFFFFF;
                        3'd1:    rgb_next = 24'hFFFF00;
                        3'd2:    rgb_next = 24'h00FFFF;
                        3'd3:    rgb_next = 24'h00FF00;
                        3'd4:    rgb_next = 24'hFF00FF;
                        3'd5:    rgb_next = 24'hFF0000;
                        3'd6:    rgb_next = 24'h0000FF;
                        default: rgb_next = 24'h000000;
                    endcase
                end
                default: rgb_next = grid_on ? 24'hFFFFFF : 24'h000000;
            endcase
        end
    end

    // ---------------- output register ----------------
    logic [23:0]        rgb_q;
    logic               hs_q, vs_q, de_q, fs_q, uf_q, flag_q;
    logic [H_width-1:0] h_q;
    logic [V_width-1:0] v_q;

    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rgb_q  <= '0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
            fs_q   <= 1'b0;
            flag_q <= 1'b0;
            uf_q   <= 1'b0;
        end else begin
            rgb_q  <= rgb_next;
            hs_q   <= tap.hs ? HS_POL : ~HS_POL;
            vs_q   <= tap.vs ? VS_POL : ~VS_POL;
            de_q   <= tap.act;
            h_q    <= tap.h;
            v_q    <= tap.v;
            fs_q   <= tap.act && (tap.h == '0) && (tap.v == '0);
            flag_q <= tap.act && tap.empty;
            // The sticky flag follows the blacked-out pixel by one clock;
            // a new underflow wins over a simultaneous clear.
            uf_q   <= flag_q || (uf_q && !vif.Underflow_clr);
        end
    end

    assign vif.Red_Sign    = rgb_q[23:16];
    assign vif.Green_Sign  = rgb_q[15:8];
    assign vif.Blue_Sign   = rgb_q[7:0];
    assign vif.H_Sync_sign = hs_q;
    assign vif.V_Sync_sign = vs_q;
    assign vif.De          = de_q;
    assign vif.H_addr      = h_q;
    assign vif.V_addr      = v_q;
    assign vif.Frame_start = fs_q;
    assign vif.Underflow   = uf_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_pattern_gen
//  Purpose  : Scoreboard bench for vga_timing_pattern_gen. A reference model
//             pushes the expected pin state for every clock; a monitor pops
//             and compares on the falling edge. Two instances run in
//             parallel: active-high syncs (a) and active-low syncs (b).
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_pattern_gen;

    localparam int HW = 4;   // $clog2(15)
    localparam int VW = 3;   // $clog2(7)

    typedef struct packed {
        logic          rd;
        logic          hs;
        logic          vs;
        logic          de;
        logic [23:0]   rgb;
        logic [HW-1:0] h;
        logic [VW-1:0] v;
        logic          fs;
        logic          uf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd2;
    logic        empty = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] fifo_data = 16'h0000;
    int          fifo_idx = 0;
    int          rd_pulses = 0;

    int n_cmp = 0;
    int n_err = 0;
    int de_cnt = 0;
    int fs_cnt = 0;
    int cyc = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    vga_timing_pattern_gen_if #(.H_width(HW), .V_width(VW)) bus_a ();
    vga_timing_pattern_gen_if #(.H_width(HW), .V_width(VW)) bus_b ();

    assign bus_a.Mode = mode;
    assign bus_a.rdata_fifo_rd_data = fifo_data;
    assign bus_a.rdata_fifo_empty = empty;
    assign bus_a.Underflow_clr = clr;
    assign bus_b.Mode = mode;
    assign bus_b.rdata_fifo_rd_data = fifo_data;
    assign bus_b.rdata_fifo_empty = empty;
    assign bus_b.Underflow_clr = clr;

    vga_timing_pattern_gen #(
        .H_Sync(2), .H_backporch(3), .H_data(8), .H_Frontporch(2),
        .V_Sync(1), .V_backporch(1), .V_data(4), .V_Frontporch(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(1)
    ) dut_a (.Sys_clk(clk), .Rst_n(rst_n), .vif(bus_a));

    vga_timing_pattern_gen #(
        .H_Sync(2), .H_backporch(3), .H_data(8), .H_Frontporch(2),
        .V_Sync(1), .V_backporch(1), .V_data(4), .V_Frontporch(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(1)
    ) dut_b (.Sys_clk(clk), .Rst_n(rst_n), .vif(bus_b));

    function automatic logic [15:0] word_of(input int i);
        case (i % 4)
            0:       return 16'hF800;
            1:       return 16'h07E0;
            2:       return 16'h001F;
            default: return 16'hFFFF;
        endcase
    endfunction

    // Hand-derived colour tables.
    function automatic logic [23:0] gray_of(input int i);
        case (i % 4)
            0:       return 24'h000000;
            1:       return 24'hE0E0E0;
            2:       return 24'h1F1F1F;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    function automatic logic [23:0] rgb565_of(input int i);
        case (i % 4)
            0:       return 24'hFF0000;
            1:       return 24'h00FF00;
            2:       return 24'h0000FF;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    function automatic logic [23:0] bar_of(input int h);
        case (h)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // FIFO with one clock of read latency.
    always @(posedge clk) begin
        if (bus_a.rdata_fifo_rd_en) begin
            fifo_data <= word_of(fifo_idx);
            fifo_idx  <= fifo_idx + 1;
            rd_pulses <= rd_pulses + 1;
        end
    end

    // ---------------- reference model ----------------
    int         m_h, m_v, widx = 0;
    logic [1:0] m_mode;
    logic       d_act, d_hs, d_vs, d_fl, m_fo, m_uf;
    logic [1:0] d_mode;
    int         d_h, d_v, d_w;

    always @(posedge clk) begin
        logic s_act, s_rd, s_fl;
        int   s_w;
        exp_t e;
        if (!rst_n) begin
            cyc = 0; m_h = 0; m_v = 0; m_mode = 2'd0;
            d_act = 0; d_hs = 0; d_vs = 0; d_fl = 0; d_mode = 2'd0;
            d_h = 0; d_v = 0; d_w = 0; m_fo = 0; m_uf = 0;
        end else begin
            s_act = (m_h >= 5 && m_h <= 12 && m_v >= 2 && m_v <= 5);
            s_rd  = s_act && (m_mode < 2);
            s_fl  = s_rd && empty;
            s_w   = widx;
            if (s_rd) widx++;

            e.hs  = d_hs;
            e.vs  = d_vs;
            e.de  = d_act;
            e.h   = d_act ? 4'(d_h) : 4'd0;
            e.v   = d_act ? 3'(d_v) : 3'd0;
            e.fs  = d_act && d_h == 0 && d_v == 0;
            if (!d_act || d_fl)      e.rgb = 24'h0;
            else if (d_mode == 2'd0) e.rgb = gray_of(d_w);
            else if (d_mode == 2'd1) e.rgb = rgb565_of(d_w);
            else if (d_mode == 2'd2) e.rgb = bar_of(d_h);
            else                     e.rgb = (d_h == 0 || d_v == 0) ? 24'hFFFFFF : 24'h0;
            e.uf  = m_fo || (m_uf && !clr);
            m_uf  = e.uf;
            m_fo  = d_act && d_fl;

            d_act = s_act; d_hs = (m_h < 2); d_vs = (m_v < 1); d_fl = s_fl;
            d_mode = m_mode; d_h = m_h - 5; d_v = m_v - 2; d_w = s_w;

            if (m_h == 0 && m_v == 0) m_mode = mode;
            if (m_h == 14) begin
                m_h = 0;
                m_v = (m_v == 6) ? 0 : m_v + 1;
            end else begin
                m_h++;
            end
            cyc++;
            e.rd = (m_h >= 5 && m_h <= 12 && m_v >= 2 && m_v <= 5) && (m_mode < 2);
            q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e, ga, gb, eb;
        if (q.size() > 0) begin
            e = q.pop_front();
            ga = {bus_a.rdata_fifo_rd_en, bus_a.H_Sync_sign, bus_a.V_Sync_sign, bus_a.De,
                  bus_a.Red_Sign, bus_a.Green_Sign, bus_a.Blue_Sign, bus_a.H_addr,
                  bus_a.V_addr, bus_a.Frame_start, bus_a.Underflow};
            gb = {bus_b.rdata_fifo_rd_en, bus_b.H_Sync_sign, bus_b.V_Sync_sign, bus_b.De,
                  bus_b.Red_Sign, bus_b.Green_Sign, bus_b.Blue_Sign, bus_b.H_addr,
                  bus_b.V_addr, bus_b.Frame_start, bus_b.Underflow};
            eb = e;
            eb.hs = ~e.hs;
            eb.vs = ~e.vs;
            n_cmp++;
            if (ga !== e) begin
                n_err++;
                $display("FAIL pins_a cyc=%0d got=%h exp=%h (rd hs vs de rgb h v fs uf)", cyc, ga, e);
            end
            n_cmp++;
            if (gb !== eb) begin
                n_err++;
                $display("FAIL pins_b cyc=%0d got=%h exp=%h (rd hs vs de rgb h v fs uf)", cyc, gb, eb);
            end
            if (bus_a.De) de_cnt++;
            if (bus_a.Frame_start) fs_cnt++;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rd_at_315, rd_at_420;
        rd_at_315 = -1;
        rd_at_420 = -1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Frames: 0,1 bars (switch to grid mid frame 1), 2 grid, 3 RGB565,
        // 4 GRAY8 with two underflows and two clears, 5 reset mid-line.
        while (cyc < 573) begin
            @(negedge clk);
            mode  = (cyc >= 350) ? 2'd0 : (cyc >= 250) ? 2'd1 : (cyc >= 150) ? 2'd3 : 2'd2;
            empty = (cyc == 457) || (cyc == 487);
            clr   = (cyc == 467) || (cyc == 489);
            if (cyc == 315) rd_at_315 = rd_pulses;
            if (cyc == 420) rd_at_420 = rd_pulses;
        end
        check("rd_en_pattern_frames", rd_at_315, 0);
        check("rd_en_rgb565_frame", rd_at_420 - rd_at_315, 32);
        check("de_count", de_cnt, 168);
        check("frame_start_count", fs_cnt, 6);
        check("underflow_before_reset", int'(bus_a.Underflow), 1);

        #2 rst_n = 1'b0;
        empty = 1'b0;
        clr   = 1'b0;
        #1;
        check("rst_hs_a", int'(bus_a.H_Sync_sign), 0);
        check("rst_vs_a", int'(bus_a.V_Sync_sign), 0);
        check("rst_hs_b", int'(bus_b.H_Sync_sign), 1);
        check("rst_vs_b", int'(bus_b.V_Sync_sign), 1);
        check("rst_de", int'(bus_a.De), 0);
        check("rst_rgb", int'({bus_a.Red_Sign, bus_a.Green_Sign, bus_a.Blue_Sign}), 0);
        check("rst_addr", int'({bus_a.H_addr, bus_a.V_addr}), 0);
        check("rst_underflow", int'(bus_a.Underflow), 0);
        check("rst_frame_start", int'(bus_a.Frame_start), 0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        while (cyc < 110) @(negedge clk);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
